// File: rtl/fetch_stage.sv
// IF stage of the five-stage WISC pipeline: PC register, I-cache request and IF/ID register.
// Absorbs I-cache misses, discards stale miss responses after a redirect, and stops on HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000,
  parameter logic [3:0]  HALT_OP   = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_wen,
  input  logic        if_id_wen,
  input  logic        if_id_flush,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted
);

  // state | meaning
  // RUN   | fetching from pc
  // DRAIN | redirect arrived during a miss; waiting for the stale word at hold_addr
  // HALT  | HLT fetched; no requests until a redirect
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALT = 2'd2} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] hold_addr;
  logic        advance;
  logic        is_hlt;

  assign advance   = pc_wen & if_id_wen;
  assign is_hlt    = (imem_rdata[15:12] == HALT_OP);
  assign imem_req  = (state != HALT);
  assign imem_addr = (state == DRAIN) ? hold_addr : pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      pc             <= RESET_PC;
      hold_addr      <= 16'h0000;
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= 16'h0000;
      if_id_pc_plus2 <= 16'h0000;
      if_id_valid    <= 1'b0;
      halted         <= 1'b0;
    end else if (br_taken) begin
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      pc          <= br_target;
      halted      <= 1'b0;
      case (state)
        RUN: begin
          // The outstanding miss still has to come back; remember which address it was for.
          if (!imem_valid) begin
            hold_addr <= pc;
            state     <= DRAIN;
          end
        end
        DRAIN:   if (imem_valid) state <= RUN;
        HALT:    state <= RUN;
        default: state <= RUN;
      endcase
    end else begin
      case (state)
        RUN: begin
          if (imem_valid && advance) begin
            if (if_id_flush) begin
              if_id_instr <= NOP_INSTR;
              if_id_valid <= 1'b0;
            end else begin
              if_id_instr    <= imem_rdata;
              if_id_pc       <= pc;
              if_id_pc_plus2 <= pc + 16'd2;
              if_id_valid    <= 1'b1;
            end
            if (is_hlt) state <= HALT;
            else        pc    <= pc + 16'd2;
          end else if (if_id_flush || (!imem_valid && if_id_wen)) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (if_id_flush || if_id_wen) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
          if (imem_valid) state <= RUN;
        end
        HALT: begin
          halted <= 1'b1;
          if (if_id_flush || if_id_wen) begin
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed walk through the fetch scenarios, then random traffic,
// all checked every cycle against a transaction-level model of the fetch stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_wen, if_id_wen, if_id_flush, br_taken;
  logic [15:0] br_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] if_id_instr, if_id_pc, if_id_pc_plus2;
  logic        if_id_valid, halted;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_wen(pc_wen), .if_id_wen(if_id_wen),
    .if_id_flush(if_id_flush), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_pc_plus2(if_id_pc_plus2), .if_id_valid(if_id_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  localparam int M_FETCH   = 0;
  localparam int M_DISCARD = 1;
  localparam int M_STOPPED = 2;

  int          m_mode;
  logic [15:0] m_pc, m_hold;
  logic [15:0] e_instr, e_pc, e_pc2;
  logic        e_valid, e_halted;

  // Program image: HLT lives at address 12, everything else has opcode < 8.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    if (a == 16'h000C) w = 16'hF000;
    else w = {1'b0, a[14:0] ^ 15'h2A5A};
    return w;
  endfunction

  function automatic logic [15:0] exp_addr();
    return (m_mode == M_DISCARD) ? m_hold : m_pc;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs();
    chk("if_id_instr", if_id_instr, e_instr);
    chk("if_id_valid", {15'd0, if_id_valid}, {15'd0, e_valid});
    chk("halted", {15'd0, halted}, {15'd0, e_halted});
    if (e_valid) begin
      chk("if_id_pc", if_id_pc, e_pc);
      chk("if_id_pc_plus2", if_id_pc_plus2, e_pc2);
    end
  endtask

  task automatic model_reset();
    m_mode = M_FETCH; m_pc = 16'h0000; m_hold = 16'h0000;
    e_instr = 16'h0000; e_pc = 16'h0000; e_pc2 = 16'h0000;
    e_valid = 1'b0; e_halted = 1'b0;
  endtask

  // One edge of the fetch stage described as "what happens to the instruction stream".
  task automatic model_step(input bit pw, input bit iw, input bit fl, input bit bt,
                            input logic [15:0] bta, input bit v, input logic [15:0] w);
    logic [15:0] old_pc;
    bit bub, ld;
    old_pc = m_pc; bub = 0; ld = 0;
    if (bt) begin
      bub = 1;
      if (m_mode == M_FETCH && !v) begin
        m_hold = m_pc; m_mode = M_DISCARD;
      end else if (m_mode == M_STOPPED || (m_mode == M_DISCARD && v)) begin
        m_mode = M_FETCH;
      end
      m_pc = bta; e_halted = 0;
    end else if (m_mode == M_FETCH) begin
      if (v && pw && iw) begin
        if (fl) bub = 1; else ld = 1;
        if (w[15:12] == 4'hF) m_mode = M_STOPPED;
        else m_pc = m_pc + 16'd2;
      end else if (fl || (!v && iw)) begin
        bub = 1;
      end
    end else begin
      if (fl || iw) bub = 1;
      if (m_mode == M_DISCARD && v) m_mode = M_FETCH;
      else if (m_mode == M_STOPPED) e_halted = 1;
    end
    if (ld) begin
      e_instr = w; e_pc = old_pc; e_pc2 = old_pc + 16'd2; e_valid = 1;
    end else if (bub) begin
      e_instr = 16'h0000; e_valid = 0;
    end
  endtask

  // Called just after a negedge: drive, check request, clock, check IF/ID at the next negedge.
  task automatic cycle(input bit pw, input bit iw, input bit fl, input bit bt,
                       input logic [15:0] bta, input bit v);
    logic [15:0] w;
    w = mem_word(exp_addr());
    pc_wen = pw; if_id_wen = iw; if_id_flush = fl; br_taken = bt; br_target = bta;
    imem_valid = v; imem_rdata = v ? w : 16'hDEAD;
    #1;
    chk("imem_req", {15'd0, imem_req}, {15'd0, (m_mode != M_STOPPED)});
    chk("imem_addr", imem_addr, exp_addr());
    @(posedge clk);
    model_step(pw, iw, fl, bt, bta, v, w);
    @(negedge clk);
    chk_regs();
  endtask

  initial begin
    rst = 1'b1;
    pc_wen = 0; if_id_wen = 0; if_id_flush = 0; br_taken = 0;
    br_target = 16'h0000; imem_valid = 0; imem_rdata = 16'h0000;
    model_reset();
    #12;
    chk("rst_instr", if_id_instr, 16'h0000);
    chk("rst_valid", {15'd0, if_id_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_req", {15'd0, imem_req}, 16'd1);
    chk("rst_addr", imem_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back hits, then a 2-cycle stall at pc=4.
    cycle(1, 1, 0, 0, 16'h0, 1);
    chk("hit_pc0", if_id_pc, 16'h0000);
    cycle(1, 1, 0, 0, 16'h0, 1);
    chk("hit_pc2", if_id_pc, 16'h0002);
    cycle(0, 0, 0, 0, 16'h0, 1);
    cycle(0, 0, 0, 0, 16'h0, 1);
    chk("stall_hold_pc", if_id_pc, 16'h0002);
    cycle(1, 1, 0, 0, 16'h0, 1);
    chk("stall_then_pc4", if_id_pc, 16'h0004);
    cycle(1, 1, 0, 0, 16'h0, 1);
    chk("hit_pc6_plus2", if_id_pc_plus2, 16'h0008);

    // 3-cycle miss at pc=8.
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 16'h0, 0);
    chk("miss_bubble", {15'd0, if_id_valid}, 16'd0);
    cycle(1, 1, 0, 0, 16'h0, 1);
    chk("miss_word8", if_id_instr, mem_word(16'h0008));

    // Redirect during a miss at pc=10: drain the stale word, then fetch 0x40.
    cycle(1, 1, 0, 1, 16'h0040, 0);
    cycle(1, 1, 0, 0, 16'h0, 0);
    chk("drain_addr", imem_addr, 16'h000A);
    cycle(1, 1, 0, 0, 16'h0, 1);
    chk("drain_discard", {15'd0, if_id_valid}, 16'd0);
    cycle(1, 1, 0, 0, 16'h0, 1);
    chk("after_drain_pc", if_id_pc, 16'h0040);

    // HLT at 12 presented once, then halted until redirect to 0x20.
    cycle(1, 1, 0, 1, 16'h000C, 1);
    cycle(1, 1, 0, 0, 16'h0, 1);
    chk("hlt_instr", if_id_instr, 16'hF000);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 16'h0, 1);
    chk("halted_set", {15'd0, halted}, 16'd1);
    chk("halt_addr", imem_addr, 16'h000C);
    cycle(1, 1, 0, 1, 16'h0020, 1);
    chk("unhalt", {15'd0, halted}, 16'd0);
    chk("unhalt_addr", imem_addr, 16'h0020);

    // PC wrap, then redirect with if_id_wen low still bubbles.
    cycle(1, 1, 0, 1, 16'hFFFE, 1);
    cycle(1, 1, 0, 0, 16'h0, 1);
    chk("wrap_pc", if_id_pc, 16'hFFFE);
    chk("wrap_addr", imem_addr, 16'h0000);
    cycle(1, 1, 0, 0, 16'h0, 1);
    cycle(0, 0, 0, 1, 16'h0100, 1);
    chk("br_nowen_bubble", {15'd0, if_id_valid}, 16'd0);
    cycle(1, 1, 1, 0, 16'h0, 1);
    chk("flush_bubble", {15'd0, if_id_valid}, 16'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] tgt;
      case ($urandom_range(0, 3))
        0: tgt = 16'h000C;
        1: tgt = 16'hFFFC;
        default: tgt = {$urandom_range(0, 255), 1'b0} & 16'hFFFE;
      endcase
      cycle($urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0,
            tgt, $urandom_range(0, 2) != 0);
    end

    // Reset in the middle of a drain returns to reset values immediately.
    cycle(1, 1, 0, 0, 16'h0, 0);
    cycle(1, 1, 0, 1, 16'h0080, 0);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_addr", imem_addr, 16'h0000);
    chk("rst_mid_req", {15'd0, imem_req}, 16'd1);
    chk_regs();
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 1, 0, 0, 16'h0, 1);
    chk("post_rst_pc", if_id_pc, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
